// File: rtl/rf_pkg.sv
// Shared parameters, types and FSM encoding for the register-file operand fetch stage.
package rf_pkg;

    localparam int unsigned NUM_LANES    = 16;
    localparam int unsigned NUM_WARPS    = 8;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned WARP_W       = $clog2(NUM_WARPS);
    localparam int unsigned ADDR_W       = $clog2(NUM_REGS);
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned STALL_W      = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LANE_DATA_W  = NUM_LANES * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    typedef logic [LANE_DATA_W-1:0] lane_data_t;
    typedef logic [NUM_LANES-1:0]   lane_mask_t;

    typedef struct packed {
        logic [WARP_W-1:0] warp;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [ADDR_W-1:0] rd;
        lane_mask_t        mask;
    } instr_t;

endpackage

// File: rtl/rf_operand_fetch_if.sv
// Issue, writeback, register_block and execute-side signals of the operand fetch stage.
interface rf_operand_fetch_if;
    import rf_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [WARP_W-1:0] issue_warp;
    logic [ADDR_W-1:0] issue_rs1;
    logic [ADDR_W-1:0] issue_rs2;
    logic              issue_use_rs1;
    logic              issue_use_rs2;
    logic [ADDR_W-1:0] issue_rd;
    lane_mask_t        issue_mask;

    logic              wb_valid;
    logic              wb_ready;
    logic [WARP_W-1:0] wb_warp;
    logic [ADDR_W-1:0] wb_rd;
    lane_mask_t        wb_mask;
    lane_data_t        wb_data;

    lane_mask_t        rf_read_en_0;
    lane_mask_t        rf_read_en_1;
    logic [ADDR_W-1:0] rf_raddr_0;
    logic [ADDR_W-1:0] rf_raddr_1;
    lane_mask_t        rf_write_en;
    logic [ADDR_W-1:0] rf_waddr;
    lane_data_t        rf_wdata;
    logic [WARP_W-1:0] rf_warp_selector;
    lane_data_t        rf_rdata_0;
    lane_data_t        rf_rdata_1;

    logic              op_valid;
    logic              op_ready;
    logic [WARP_W-1:0] op_warp;
    logic [ADDR_W-1:0] op_rd;
    lane_mask_t        op_mask;
    lane_data_t        op_a;
    lane_data_t        op_b;

    // Environment side: issue, writeback source, register_block data and execute stage.
    modport master (
        output issue_valid, issue_warp, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_mask,
        input  issue_ready,
        output wb_valid, wb_warp, wb_rd, wb_mask, wb_data,
        input  wb_ready,
        input  rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
               rf_write_en, rf_waddr, rf_wdata, rf_warp_selector,
        output rf_rdata_0, rf_rdata_1,
        input  op_valid, op_warp, op_rd, op_mask, op_a, op_b,
        output op_ready
    );

    // Operand fetch stage side.
    modport slave (
        input  issue_valid, issue_warp, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_mask,
        output issue_ready,
        input  wb_valid, wb_warp, wb_rd, wb_mask, wb_data,
        output wb_ready,
        output rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
               rf_write_en, rf_waddr, rf_wdata, rf_warp_selector,
        input  rf_rdata_0, rf_rdata_1,
        output op_valid, op_warp, op_rd, op_mask, op_a, op_b,
        input  op_ready
    );

endinterface

// File: rtl/rf_lane_bypass.sv
// Per-lane operand select: zero for inactive lanes, else writeback bypass or register read data.
module rf_lane_bypass
    import rf_pkg::*;
(
    input  lane_mask_t lane_en,
    input  lane_mask_t byp_en,
    input  lane_data_t rdata,
    input  lane_data_t wb_data,
    output lane_data_t data_c
);

    // Lane mux; bypass wins over the register read for lanes being written this cycle.
    always_comb begin
        data_c = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_en[i]) begin
                data_c[i*DATA_W +: DATA_W] = byp_en[i] ? wb_data[i*DATA_W +: DATA_W]
                                                       : rdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: holds one instruction, reads both sources from register_block,
// owns the writeback port and arbitrates the shared warp selector between them.
module rf_operand_fetch
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rf_operand_fetch_if.slave bus
);

    fetch_state_e      state_q, state_d;
    instr_t            instr_q, instr_d;
    lane_data_t        op_a_q, op_a_d;
    lane_data_t        op_b_q, op_b_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [WARP_W-1:0] sel_q, sel_d;

    logic              issue_ready_c;
    logic              wb_ready_c;
    logic              wb_fire;
    logic              issue_fire;
    logic              fetch_blocked;
    logic              fetch_go;
    lane_mask_t        lane_en_a, lane_en_b;
    lane_mask_t        byp_en_a, byp_en_b;
    lane_data_t        src_a_c, src_b_c;

    lane_mask_t        rd_en_0_c, rd_en_1_c, wr_en_c;
    logic [ADDR_W-1:0] raddr_0_c, raddr_1_c, waddr_c;
    lane_data_t        wdata_c;
    logic [WARP_W-1:0] warp_sel_c;

    // Handshake decode and writeback-vs-fetch arbitration.
    always_comb begin
        wb_ready_c    = !rst && (stall_q != STALL_W'(STARVE_LIMIT));
        issue_ready_c = !rst && ((state_q == IDLE) || ((state_q == VALID) && bus.op_ready));
        wb_fire       = bus.wb_valid && wb_ready_c;
        issue_fire    = bus.issue_valid && issue_ready_c;
        fetch_blocked = wb_fire && (bus.wb_warp != instr_q.warp);
        fetch_go      = !rst && (state_q == FETCH) && !fetch_blocked;
        lane_en_a     = instr_q.mask & {NUM_LANES{instr_q.use_rs1}};
        lane_en_b     = instr_q.mask & {NUM_LANES{instr_q.use_rs2}};
        byp_en_a      = '0;
        byp_en_b      = '0;
        if (wb_fire && (bus.wb_warp == instr_q.warp)) begin
            if (bus.wb_rd == instr_q.rs1) byp_en_a = bus.wb_mask;
            if (bus.wb_rd == instr_q.rs2) byp_en_b = bus.wb_mask;
        end
    end

    rf_lane_bypass u_bypass_a (
        .lane_en (lane_en_a),
        .byp_en  (byp_en_a),
        .rdata   (bus.rf_rdata_0),
        .wb_data (bus.wb_data),
        .data_c  (src_a_c)
    );

    rf_lane_bypass u_bypass_b (
        .lane_en (lane_en_b),
        .byp_en  (byp_en_b),
        .rdata   (bus.rf_rdata_1),
        .wb_data (bus.wb_data),
        .data_c  (src_b_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_fire) state_d = FETCH;
            FETCH:   if (fetch_go) state_d = VALID;
            VALID:   if (bus.op_ready) state_d = bus.issue_valid ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // register_block port drive; everything is quiet while reset is asserted.
    always_comb begin
        rd_en_0_c  = '0;
        rd_en_1_c  = '0;
        raddr_0_c  = '0;
        raddr_1_c  = '0;
        wr_en_c    = '0;
        waddr_c    = '0;
        wdata_c    = '0;
        warp_sel_c = '0;
        if (!rst) begin
            if (wb_fire) begin
                wr_en_c = bus.wb_mask;
                waddr_c = bus.wb_rd;
                wdata_c = bus.wb_data;
            end
            if (state_q == FETCH) begin
                raddr_0_c = instr_q.rs1;
                raddr_1_c = instr_q.rs2;
            end
            if (fetch_go) begin
                rd_en_0_c = lane_en_a;
                rd_en_1_c = lane_en_b;
            end
            warp_sel_c = sel_d;
        end
    end

    // Instruction capture, operand capture, starvation counter and selector history.
    always_comb begin
        instr_d = instr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        stall_d = stall_q;
        sel_d   = sel_q;
        if (issue_fire) begin
            instr_d.warp    = bus.issue_warp;
            instr_d.rs1     = bus.issue_rs1;
            instr_d.rs2     = bus.issue_rs2;
            instr_d.use_rs1 = bus.issue_use_rs1;
            instr_d.use_rs2 = bus.issue_use_rs2;
            instr_d.rd      = bus.issue_rd;
            instr_d.mask    = bus.issue_mask;
        end
        if (fetch_go) begin
            op_a_d  = src_a_c;
            op_b_d  = src_b_c;
            stall_d = '0;
        end else if ((state_q == FETCH) && fetch_blocked
                     && (stall_q != STALL_W'(STARVE_LIMIT))) begin
            stall_d = stall_q + 1'b1;
        end
        if (wb_fire)                 sel_d = bus.wb_warp;
        else if (state_q == FETCH)   sel_d = instr_q.warp;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            stall_q <= '0;
            sel_q   <= '0;
        end else begin
            instr_q <= instr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            stall_q <= stall_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.issue_ready      = issue_ready_c;
    assign bus.wb_ready         = wb_ready_c;
    assign bus.rf_read_en_0     = rd_en_0_c;
    assign bus.rf_read_en_1     = rd_en_1_c;
    assign bus.rf_raddr_0       = raddr_0_c;
    assign bus.rf_raddr_1       = raddr_1_c;
    assign bus.rf_write_en      = wr_en_c;
    assign bus.rf_waddr         = waddr_c;
    assign bus.rf_wdata         = wdata_c;
    assign bus.rf_warp_selector = warp_sel_c;
    assign bus.op_valid         = (state_q == VALID);
    assign bus.op_warp          = instr_q.warp;
    assign bus.op_rd            = instr_q.rd;
    assign bus.op_mask          = instr_q.mask;
    assign bus.op_a             = op_a_q;
    assign bus.op_b             = op_b_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch: behavioural register file plus golden per-warp/reg/lane model.
module tb_rf_operand_fetch;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    always #5 clk = ~clk;

    rf_operand_fetch_if bus ();

    rf_operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem  [NUM_WARPS][NUM_REGS][NUM_LANES];
    logic [DATA_W-1:0] gold [NUM_WARPS][NUM_REGS][NUM_LANES];
    int n_vec = 0;
    int n_err = 0;
    instr_t cur;
    lane_data_t last_a, last_b;

    // register_block stand-in: combinational reads, writes on the clock edge
    always_comb begin
        lane_data_t d0, d1;
        d0 = '0;
        d1 = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            d0[l*DATA_W +: DATA_W] = mem[bus.rf_warp_selector][bus.rf_raddr_0][l];
            d1[l*DATA_W +: DATA_W] = mem[bus.rf_warp_selector][bus.rf_raddr_1][l];
        end
        bus.rf_rdata_0 = d0;
        bus.rf_rdata_1 = d1;
    end

    always @(posedge clk) begin
        for (int unsigned w = 0; w < NUM_WARPS; w++)
            for (int unsigned r = 0; r < NUM_REGS; r++)
                for (int unsigned l = 0; l < NUM_LANES; l++)
                    if (mem_clr)
                        mem[w][r][l] <= '0;
                    else if (bus.rf_write_en[l] && (bus.rf_warp_selector == WARP_W'(w))
                             && (bus.rf_waddr == ADDR_W'(r)))
                        mem[w][r][l] <= bus.rf_wdata[l*DATA_W +: DATA_W];
    end

    function automatic lane_data_t exp_src(input logic [WARP_W-1:0] w, input logic [ADDR_W-1:0] r,
                                           input logic u, input lane_mask_t m);
        lane_data_t v = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++)
            if (u && m[l]) v[l*DATA_W +: DATA_W] = gold[w][r][l];
        return v;
    endfunction

    function automatic lane_data_t rand_data();
        lane_data_t v;
        for (int unsigned l = 0; l < NUM_LANES; l++) v[l*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    task automatic gold_write(input logic [WARP_W-1:0] w, input logic [ADDR_W-1:0] r,
                              input lane_mask_t m, input lane_data_t d);
        for (int unsigned l = 0; l < NUM_LANES; l++)
            if (m[l]) gold[w][r][l] = d[l*DATA_W +: DATA_W];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid   = 1'b0;
        bus.issue_warp    = '0;
        bus.issue_rs1     = '0;
        bus.issue_rs2     = '0;
        bus.issue_use_rs1 = 1'b0;
        bus.issue_use_rs2 = 1'b0;
        bus.issue_rd      = '0;
        bus.issue_mask    = '0;
        bus.wb_valid      = 1'b0;
        bus.wb_warp       = '0;
        bus.wb_rd         = '0;
        bus.wb_mask       = '0;
        bus.wb_data       = '0;
        bus.op_ready      = 1'b0;
    endtask

    task automatic drive_wb(input logic [WARP_W-1:0] w, input logic [ADDR_W-1:0] r,
                            input lane_mask_t m, input lane_data_t d);
        bus.wb_valid = 1'b1;
        bus.wb_warp  = w;
        bus.wb_rd    = r;
        bus.wb_mask  = m;
        bus.wb_data  = d;
    endtask

    // Writeback while no fetch is pending: always accepted, committed at the next edge.
    task automatic do_wb(input logic [WARP_W-1:0] w, input logic [ADDR_W-1:0] r,
                         input lane_mask_t m, input lane_data_t d);
        drive_wb(w, r, m, d);
        #1;
        n_vec++;
        if ({bus.wb_ready, bus.rf_write_en, bus.rf_waddr, bus.rf_warp_selector} !== {1'b1, m, r, w}) begin
            n_err++;
            $display("FAIL wb_drive: got rdy=%b en=%h addr=%0d sel=%0d, expected rdy=1 en=%h addr=%0d sel=%0d",
                     bus.wb_ready, bus.rf_write_en, bus.rf_waddr, bus.rf_warp_selector, m, r, w);
        end
        gold_write(w, r, m, d);
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic issue(input instr_t t);
        bus.issue_valid   = 1'b1;
        bus.issue_warp    = t.warp;
        bus.issue_rs1     = t.rs1;
        bus.issue_rs2     = t.rs2;
        bus.issue_use_rs1 = t.use_rs1;
        bus.issue_use_rs2 = t.use_rs2;
        bus.issue_rd      = t.rd;
        bus.issue_mask    = t.mask;
        #1;
        n_vec++;
        if (bus.issue_ready !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready: got %b expected 1", bus.issue_ready);
        end
        tick();
        bus.issue_valid = 1'b0;
        cur = t;
    endtask

    // A FETCH cycle that must complete; any writeback already driven is reflected in gold.
    task automatic fetch_cycle();
        lane_data_t ea, eb;
        ea = exp_src(cur.warp, cur.rs1, cur.use_rs1, cur.mask);
        eb = exp_src(cur.warp, cur.rs2, cur.use_rs2, cur.mask);
        #1;
        n_vec++;
        if ({bus.op_valid, bus.rf_read_en_0, bus.rf_read_en_1, bus.rf_warp_selector}
            !== {1'b0, cur.mask & {NUM_LANES{cur.use_rs1}}, cur.mask & {NUM_LANES{cur.use_rs2}}, cur.warp}
            || (cur.use_rs1 && bus.rf_raddr_0 !== cur.rs1) || (cur.use_rs2 && bus.rf_raddr_1 !== cur.rs2)) begin
            n_err++;
            $display("FAIL fetch_drive: got v=%b en0=%h en1=%h a0=%0d a1=%0d sel=%0d, expected w%0d rs%0d/%0d mask=%h use=%b%b",
                     bus.op_valid, bus.rf_read_en_0, bus.rf_read_en_1, bus.rf_raddr_0, bus.rf_raddr_1,
                     bus.rf_warp_selector, cur.warp, cur.rs1, cur.rs2, cur.mask, cur.use_rs1, cur.use_rs2);
        end
        tick();
        bus.wb_valid = 1'b0;
        n_vec++;
        if ({bus.op_valid, bus.op_warp, bus.op_rd, bus.op_mask, bus.wb_ready}
            !== {1'b1, cur.warp, cur.rd, cur.mask, 1'b1}) begin
            n_err++;
            $display("FAIL op_ctrl: got v=%b w=%0d rd=%0d m=%h wrdy=%b, expected v=1 w=%0d rd=%0d m=%h wrdy=1",
                     bus.op_valid, bus.op_warp, bus.op_rd, bus.op_mask, bus.wb_ready, cur.warp, cur.rd, cur.mask);
        end
        n_vec++;
        if (bus.op_a !== ea) begin
            n_err++;
            $display("FAIL op_a: got %h expected %h", bus.op_a, ea);
        end
        n_vec++;
        if (bus.op_b !== eb) begin
            n_err++;
            $display("FAIL op_b: got %h expected %h", bus.op_b, eb);
        end
        last_a = ea;
        last_b = eb;
    endtask

    task automatic hold_cycles(input int n);
        bus.op_ready = 1'b0;
        for (int c = 0; c < n; c++) begin
            tick();
            n_vec++;
            if ({bus.op_valid, bus.issue_ready, bus.op_a, bus.op_b} !== {1'b1, 1'b0, last_a, last_b}) begin
                n_err++;
                $display("FAIL op_hold: cycle %0d got v=%b irdy=%b a=%h b=%h, expected v=1 irdy=0 a=%h b=%h",
                         c, bus.op_valid, bus.issue_ready, bus.op_a, bus.op_b, last_a, last_b);
            end
        end
    endtask

    task automatic release_op();
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        n_vec++;
        if ({bus.op_valid, bus.issue_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL release: got v=%b irdy=%b expected v=0 irdy=1", bus.op_valid, bus.issue_ready);
        end
    endtask

    function automatic instr_t mk(input int w, input int r1, input int r2, input bit u1, input bit u2,
                                  input int rd, input lane_mask_t m);
        instr_t t;
        t.warp = WARP_W'(w); t.rs1 = ADDR_W'(r1); t.rs2 = ADDR_W'(r2);
        t.use_rs1 = u1; t.use_rs2 = u2; t.rd = ADDR_W'(rd); t.mask = m;
        return t;
    endfunction

    task automatic test_reset();
        idle_inputs();
        for (int unsigned w = 0; w < NUM_WARPS; w++)
            for (int unsigned r = 0; r < NUM_REGS; r++)
                for (int unsigned l = 0; l < NUM_LANES; l++) gold[w][r][l] = '0;
        rst = 1'b1;
        mem_clr = 1'b1;
        drive_wb(3'd5, 5'd9, 16'hFFFF, rand_data());
        bus.issue_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if ({bus.issue_ready, bus.wb_ready, bus.rf_read_en_0, bus.rf_read_en_1, bus.rf_write_en,
                 bus.rf_waddr, bus.rf_warp_selector, bus.op_valid} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: cycle %0d irdy=%b wrdy=%b wen=%h sel=%0d v=%b, expected all 0",
                         c, bus.issue_ready, bus.wb_ready, bus.rf_write_en, bus.rf_warp_selector, bus.op_valid);
            end
        end
        rst = 1'b0;
        mem_clr = 1'b0;
        idle_inputs();
        #1;
        n_vec++;
        if ({bus.op_valid, bus.wb_ready, bus.issue_ready, bus.rf_read_en_0, bus.rf_read_en_1, bus.op_a}
            !== {1'b0, 1'b1, 1'b1, 16'h0, 16'h0, LANE_DATA_W'(0)}) begin
            n_err++;
            $display("FAIL after_reset: got v=%b wrdy=%b irdy=%b en0=%h en1=%h, expected 0 1 1 0 0",
                     bus.op_valid, bus.wb_ready, bus.issue_ready, bus.rf_read_en_0, bus.rf_read_en_1);
        end
        tick();
    endtask

    task automatic test_basic();
        lane_data_t d;
        for (int unsigned l = 0; l < NUM_LANES; l++) d[l*DATA_W +: DATA_W] = 32'hA5A5_0000 + l;
        do_wb(3'd2, 5'd5, 16'hFFFF, d);
        issue(mk(2, 5, 0, 1, 0, 9, 16'hFFFF));
        fetch_cycle();
        n_vec++;
        if (bus.op_a[3*DATA_W +: DATA_W] !== 32'hA5A5_0003) begin
            n_err++;
            $display("FAIL basic_lane3: got %h expected a5a50003", bus.op_a[3*DATA_W +: DATA_W]);
        end
        release_op();
    endtask

    task automatic test_mask_hold();
        do_wb(3'd3, 5'd10, 16'hFFFF, rand_data());
        do_wb(3'd3, 5'd11, 16'hFFFF, rand_data());
        issue(mk(3, 10, 11, 1, 1, 4, 16'h00F0));
        fetch_cycle();
        bus.issue_valid = 1'b1;
        hold_cycles(5);
        bus.issue_valid = 1'b0;
        release_op();
    endtask

    task automatic test_bypass();
        lane_data_t d;
        do_wb(3'd1, 5'd7, 16'hFFFF, rand_data());
        issue(mk(1, 7, 7, 1, 1, 2, 16'hFFFF));
        d = rand_data();
        d[DATA_W-1:0] = 32'hDEAD_BEEF;
        drive_wb(3'd1, 5'd7, 16'h0001, d);
        gold_write(3'd1, 5'd7, 16'h0001, d);
        fetch_cycle();
        n_vec++;
        if (bus.op_a[DATA_W-1:0] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL bypass_lane0: got %h expected deadbeef", bus.op_a[DATA_W-1:0]);
        end
        release_op();
    endtask

    task automatic test_starve();
        lane_data_t d;
        do_wb(3'd4, 5'd2, 16'hFFFF, rand_data());
        issue(mk(4, 2, 0, 1, 0, 1, 16'hFFFF));
        d = rand_data();
        drive_wb(3'd0, 5'd3, 16'hFFFF, d);
        gold_write(3'd0, 5'd3, 16'hFFFF, d);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if ({bus.wb_ready, bus.rf_warp_selector, bus.rf_read_en_0, bus.op_valid} !== {1'b1, 3'd0, 16'h0, 1'b0}) begin
                n_err++;
                $display("FAIL starve_blocked: cycle %0d got wrdy=%b sel=%0d en0=%h v=%b, expected 1 0 0 0",
                         c, bus.wb_ready, bus.rf_warp_selector, bus.rf_read_en_0, bus.op_valid);
            end
            @(posedge clk);
            #1;
        end
        #1;
        n_vec++;
        if (bus.wb_ready !== 1'b0) begin
            n_err++;
            $display("FAIL starve_hold: got wrdy=%b expected 0", bus.wb_ready);
        end
        fetch_cycle();
        release_op();
        issue(mk(0, 3, 3, 1, 0, 0, 16'hFFFF));
        fetch_cycle();
        release_op();
    endtask

    task automatic test_back_to_back();
        do_wb(3'd5, 5'd1, 16'hFFFF, rand_data());
        do_wb(3'd6, 5'd4, 16'hFFFF, rand_data());
        do_wb(3'd6, 5'd5, 16'hFFFF, rand_data());
        issue(mk(5, 1, 2, 1, 1, 3, 16'hFFFF));
        fetch_cycle();
        bus.op_ready = 1'b1;
        issue(mk(6, 4, 5, 1, 1, 8, 16'h5A3C));
        bus.op_ready = 1'b0;
        fetch_cycle();
        release_op();
    endtask

    task automatic test_reset_mid();
        issue(mk(2, 5, 0, 1, 0, 9, 16'hFFFF));
        fetch_cycle();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({bus.op_valid, bus.issue_ready, bus.op_warp, bus.op_rd, bus.op_mask, bus.op_a, bus.op_b} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b irdy=%b w=%0d m=%h a=%h, expected all 0",
                     bus.op_valid, bus.issue_ready, bus.op_warp, bus.op_mask, bus.op_a);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.issue_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_ready: got %b expected 1", bus.issue_ready);
        end
        tick();
        issue(mk(3, 10, 11, 1, 1, 6, 16'hFFFF));
        fetch_cycle();
        release_op();
    endtask

    task automatic test_random();
        instr_t t;
        lane_data_t d;
        logic [WARP_W-1:0] ww;
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 8; r++) do_wb(WARP_W'(w), ADDR_W'(r), 16'hFFFF, rand_data());
        for (int k = 0; k < 40; k++) begin
            t = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom), $urandom_range(0, 31), lane_mask_t'($urandom));
            issue(t);
            case ($urandom_range(0, 2))
                0: fetch_cycle();
                1: begin
                    d = rand_data();
                    drive_wb(t.warp, ADDR_W'($urandom_range(0, 7)), lane_mask_t'($urandom), d);
                    gold_write(t.warp, bus.wb_rd, bus.wb_mask, d);
                    fetch_cycle();
                end
                default: begin
                    d = rand_data();
                    ww = WARP_W'((int'(t.warp) + $urandom_range(1, 7)) % 8);
                    drive_wb(ww, ADDR_W'($urandom_range(0, 7)), lane_mask_t'($urandom), d);
                    #1;
                    n_vec++;
                    if ({bus.wb_ready, bus.rf_read_en_0, bus.rf_read_en_1, bus.rf_warp_selector} !== {1'b1, 32'h0, ww}) begin
                        n_err++;
                        $display("FAIL rand_blocked: got wrdy=%b en0=%h en1=%h sel=%0d, expected 1 0 0 %0d",
                                 bus.wb_ready, bus.rf_read_en_0, bus.rf_read_en_1, bus.rf_warp_selector, ww);
                    end
                    gold_write(ww, bus.wb_rd, bus.wb_mask, d);
                    tick();
                    bus.wb_valid = 1'b0;
                    fetch_cycle();
                end
            endcase
            hold_cycles($urandom_range(0, 3));
            release_op();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask_hold();
        test_bypass();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
